// File: rtl/store_buffer_ctrl_pkg.sv
// store_buffer_ctrl_pkg
//   Shared definitions for the store buffer: WLen encodings, the controller
//   FSM state encodings and the layout of one queued store.
//   No ports (package).
package store_buffer_ctrl_pkg;

  // Store width encodings carried alongside every queued store.
  localparam logic [1:0] WLEN_BYTE   = 2'b00;
  localparam logic [1:0] WLEN_HALF   = 2'b01;
  localparam logic [1:0] WLEN_TRIPLE = 2'b10;
  localparam logic [1:0] WLEN_WORD   = 2'b11;

  // Controller FSM encodings.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] LD_BUSY = 2'd2;

  // One queued store: already-aligned address, data and width.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  wlen;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo
//   Circular store queue with per-entry word-address comparators.
//   Ports:
//     clk, reset        clock and synchronous active-low reset
//     push, push_entry  enqueue request and the store to enqueue (ignored when full)
//     pop               dequeue the head entry (ignored when empty)
//     cmp_word          word address (addr[31:2]) to look up among valid entries
//     head              current head entry
//     hit               some valid entry matches cmp_word
//     empty, full       queue status
module sb_fifo
  import store_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  sb_entry_t   push_entry,
  input  logic [29:0] cmp_word,
  output sb_entry_t   head,
  output logic        hit,
  output logic        empty,
  output logic        full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        valid[wr_ptr]  <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        valid[rd_ptr]  <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  // Word-granular match against every valid entry.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr[31:2] == cmp_word)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl
//   Store buffer in front of a single-port data memory. Stores are queued
//   and drained one at a time; loads take priority unless they hit a queued
//   store (word granularity) or the queue is full.
//   Ports:
//     clk, reset                         clock, synchronous active-low reset
//     st_valid/st_addr/st_data/st_wlen   store request from MEM; st_ready = accepted
//     ld_valid/ld_addr                   load request; ld_done pulse, ld_stall
//     mem_req/mem_we/mem_addr/mem_wdata/mem_wlen, mem_ack   data memory port
//     empty, full                        queue status
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_wlen,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_done,
  output logic        ld_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wlen,
  input  logic        mem_ack,
  output logic        empty,
  output logic        full
);

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [31:0] ld_addr_q;
  sb_entry_t   push_entry;
  sb_entry_t   head;
  logic        hit;
  logic        hazard;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;

  assign push_entry = {st_addr, st_data, st_wlen};
  assign hazard     = ld_valid && hit;
  assign pop        = reset && (state == ST_BUSY) && mem_ack;

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (st_valid),
    .pop        (pop),
    .push_entry (push_entry),
    .cmp_word   (ld_addr[31:2]),
    .head       (head),
    .hit        (hit),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Status outputs show the reset values while reset is held, before the
  // registers have been cleared by the first edge.
  assign st_ready = !reset || !fifo_full;
  assign empty    = !reset || fifo_empty;
  assign full     = reset && fifo_full;
  assign ld_done  = reset && (state == LD_BUSY) && mem_ack;
  assign ld_stall = ld_valid && !ld_done;

  // Every busy state returns to IDLE on ack, which guarantees a request-free
  // cycle between accesses. A full queue blocks loads so draining cannot starve.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (ld_valid && !hazard && !fifo_full) begin
          next_state = LD_BUSY;
        end else if (!fifo_empty) begin
          next_state = ST_BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      ST_BUSY: next_state = mem_ack ? IDLE : ST_BUSY;
      LD_BUSY: next_state = mem_ack ? IDLE : LD_BUSY;
      default: next_state = IDLE;
    endcase
  end

  // The load address is captured on entry so the read stays stable even if
  // the requester changes ld_addr mid-access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ld_addr_q <= '0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && (next_state == LD_BUSY)) begin
        ld_addr_q <= ld_addr;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wlen  = '0;
    if (reset) begin
      case (state)
        ST_BUSY: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = head.addr;
          mem_wdata = head.data;
          mem_wlen  = head.wlen;
        end
        LD_BUSY: begin
          mem_req  = 1'b1;
          mem_addr = ld_addr_q;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb_store_buffer_ctrl
//   Directed bench for store_buffer_ctrl with hand-computed expectations.
module tb_store_buffer_ctrl;
  import store_buffer_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_wlen;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_done;
  logic        ld_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wlen;
  logic        mem_ack;
  logic        empty;
  logic        full;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_pops       = 0;
  int n_ld_done    = 0;

  store_buffer_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_wlen   (st_wlen),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_done   (ld_done),
    .ld_stall  (ld_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wlen  (mem_wlen),
    .mem_ack   (mem_ack),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  // Count completed store writes and load completions mid-cycle.
  always @(negedge clk) begin
    if (reset && mem_req && mem_we && mem_ack) n_pops <= n_pops + 1;
    if (ld_done) n_ld_done <= n_ld_done + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic [1:0] sw,
                               input logic lv, input logic [31:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    st_wlen  = sw;
    ld_valid = lv;
    ld_addr  = la;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b0;
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic waitReq(input string tag);
    for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
    checkOutput(tag, {31'd0, mem_req}, 32'd1);
  endtask

  task automatic drainStore(input string tag, input logic [31:0] addr);
    waitReq({tag, "_req"});
    checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    checkOutput({tag, "_addr"}, mem_addr, addr);
    mem_ack = 1'b1;
    #1;
    tick();
    mem_ack = 1'b0;
    #1;
    checkOutput({tag, "_gap"}, {31'd0, mem_req}, 32'd0);
  endtask

  int          pushed;
  int          popped;
  logic        acc;

  initial begin
    // Reset held: outputs must already show reset values.
    reset   = 1'b0;
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    tick();
    checkOutput("rst_in_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_in_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_in_full", {31'd0, full}, 32'd0);
    checkOutput("rst_in_st_ready", {31'd0, st_ready}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_wlen", {30'd0, mem_wlen}, 32'd0);
    checkOutput("rst_ld_done", {31'd0, ld_done}, 32'd0);
    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_st_ready", {31'd0, st_ready}, 32'd1);

    // Single store: write appears two cycles after the request.
    applyStimulus(1'b1, 32'h104, 32'hA5, WLEN_BYTE, 1'b0, 32'h0);
    checkOutput("s1_st_ready", {31'd0, st_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    checkOutput("s1_not_empty", {31'd0, empty}, 32'd0);
    checkOutput("s1_req_c1", {31'd0, mem_req}, 32'd0);
    tick();
    checkOutput("s1_req_c2", {31'd0, mem_req}, 32'd1);
    checkOutput("s1_we", {31'd0, mem_we}, 32'd1);
    checkOutput("s1_addr", mem_addr, 32'h104);
    checkOutput("s1_wdata", mem_wdata, 32'hA5);
    checkOutput("s1_wlen", {30'd0, mem_wlen}, 32'd0);
    tick();
    checkOutput("s1_addr_hold", mem_addr, 32'h104);
    mem_ack = 1'b1;
    #1;
    tick();
    mem_ack = 1'b0;
    #1;
    checkOutput("s1_empty", {31'd0, empty}, 32'd1);
    checkOutput("s1_gap", {31'd0, mem_req}, 32'd0);

    // Fill: five back-to-back stores, no acks; the fifth is refused.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), 32'h50 + 32'(i), WLEN_WORD, 1'b0, 32'h0);
      if (i == 4) checkOutput("fill_st_ready", {31'd0, st_ready}, 32'd0);
      tick();
      if (i == 3) checkOutput("fill_full", {31'd0, full}, 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    checkOutput("fill_full_hold", {31'd0, full}, 32'd1);
    for (int i = 0; i < 4; i++) drainStore("fill_drain", 32'h500 + 32'(4 * i));
    checkOutput("fill_empty", {31'd0, empty}, 32'd1);

    // Load hazard: store to 0x200 drains before the read of 0x203.
    doReset();
    applyStimulus(1'b1, 32'h200, 32'hDEAD, WLEN_WORD, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b1, 32'h203);
    checkOutput("hz_stall", {31'd0, ld_stall}, 32'd1);
    tick();
    checkOutput("hz_wr_we", {31'd0, mem_we}, 32'd1);
    checkOutput("hz_wr_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    #1;
    checkOutput("hz_stall_wr", {31'd0, ld_stall}, 32'd1);
    tick();
    mem_ack = 1'b0;
    #1;
    checkOutput("hz_gap", {31'd0, mem_req}, 32'd0);
    tick();
    checkOutput("hz_rd_req", {31'd0, mem_req}, 32'd1);
    checkOutput("hz_rd_we", {31'd0, mem_we}, 32'd0);
    checkOutput("hz_rd_addr", mem_addr, 32'h203);
    checkOutput("hz_rd_wdata", mem_wdata, 32'h0);
    checkOutput("hz_no_done", {31'd0, ld_done}, 32'd0);
    mem_ack = 1'b1;
    #1;
    checkOutput("hz_done", {31'd0, ld_done}, 32'd1);
    checkOutput("hz_stall_clr", {31'd0, ld_stall}, 32'd0);
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    checkOutput("hz_done_pulse", {31'd0, ld_done}, 32'd0);
    checkOutput("hz_ld_count", n_ld_done, 32'd1);

    // Load priority: read of 0x400 goes before the queued write of 0x300.
    doReset();
    applyStimulus(1'b1, 32'h300, 32'h33, WLEN_TRIPLE, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b1, 32'h400);
    tick();
    checkOutput("pri_rd_req", {31'd0, mem_req}, 32'd1);
    checkOutput("pri_rd_we", {31'd0, mem_we}, 32'd0);
    checkOutput("pri_rd_addr", mem_addr, 32'h400);
    mem_ack = 1'b1;
    #1;
    tick();
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    drainStore("pri_wr", 32'h300);
    checkOutput("pri_ld_count", n_ld_done, 32'd2);

    // Wrap: seven stores through four slots, ack every other cycle.
    doReset();
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 80 && popped < 7; cyc++) begin
      applyStimulus(pushed < 7, 32'h600 + 32'(4 * pushed), 32'h6000 + 32'(pushed),
                    WLEN_HALF, 1'b0, 32'h0);
      mem_ack = ((cyc % 2) == 1) && mem_req;
      #1;
      acc = st_valid && st_ready;
      if (mem_req && mem_ack && mem_we) begin
        checkOutput("wrap_order", mem_addr, 32'h600 + 32'(4 * popped));
        checkOutput("wrap_data", mem_wdata, 32'h6000 + 32'(popped));
        popped++;
      end
      tick();
      if (acc) pushed++;
    end
    mem_ack = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    checkOutput("wrap_popped", popped, 32'd7);
    checkOutput("wrap_empty", {31'd0, empty}, 32'd1);

    // Reset mid-request: write abandoned, queue discarded, no pop.
    doReset();
    applyStimulus(1'b1, 32'h700, 32'h70, WLEN_WORD, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h704, 32'h71, WLEN_WORD, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, WLEN_BYTE, 1'b0, 32'h0);
    waitReq("mid_req");
    reset   = 1'b0;
    mem_ack = 1'b1;
    #1;
    checkOutput("mid_req_gated", {31'd0, mem_req}, 32'd0);
    checkOutput("mid_no_done", {31'd0, ld_done}, 32'd0);
    tick();
    reset   = 1'b1;
    mem_ack = 1'b0;
    #1;
    checkOutput("mid_req_after", {31'd0, mem_req}, 32'd0);
    checkOutput("mid_empty", {31'd0, empty}, 32'd1);
    checkOutput("mid_full", {31'd0, full}, 32'd0);
    checkOutput("mid_st_ready", {31'd0, st_ready}, 32'd1);
    tick();
    checkOutput("mid_idle", {31'd0, mem_req}, 32'd0);
    checkOutput("mid_pop_count", n_pops, 32'd14);
    checkOutput("mid_ld_count", n_ld_done, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
